bram_arbiter: RTL and testbench

- Shares one single-port synchronous BRAM (the bram_example instance, 32 x 4) between two requesters.
- After reset it clears every BRAM word to zero.
- After the clear it grants accesses round-robin and registers all BRAM-side signals.
- It returns read data to the winning requester with a valid strobe.
- It sits between the BRAM and the two client blocks, which see a simple req/gnt/rvalid handshake.

---
 rtl/bram_arbiter.sv | 147 ++++++++++++++
 tb/tb_bram_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous BRAM between two requesters.
// Zero-fills the BRAM after reset, then serves req/gnt/rvalid handshakes with registered BRAM signals.
module bram_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  input  logic [DATA_W-1:0] bram_rdata
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  localparam state_t RESET_STATE = CLEAR_EN ? S_CLEAR : S_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                ready_q, ready_d;
  logic                prio_q, prio_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                elig0, elig1, win0, win1;

  // Next-state logic: clear sequencing, arbitration and BRAM-side staging.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    prio_d    = prio_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    // A requester granted this cycle is still holding req; skip it so it is not granted twice.
    elig0     = req0 & ~gnt0_q;
    elig1     = req1 & ~gnt1_q;
    // prio_q = 1 means requester 1 wins a tie.
    win0      = elig0 & (~elig1 | ~prio_q);
    win1      = elig1 & (~elig0 | prio_q);
    rvalid0_d = gnt0_q & ~we_q;
    rvalid1_d = gnt1_q & ~we_q;

    case (state_q)
      S_CLEAR: begin
        we_d      = 1'b1;
        addr_d    = clr_cnt_q;
        wdata_d   = {DATA_W{1'b0}};
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = S_RUN;
        end else begin
          state_d = S_CLEAR;
        end
      end
      S_RUN: begin
        // ready lags entry into RUN by one cycle, so the last clear write is not overlapped.
        ready_d = 1'b1;
        if (ready_q && win0) begin
          gnt0_d  = 1'b1;
          we_d    = we0;
          addr_d  = addr0;
          wdata_d = wdata0;
          prio_d  = 1'b1;
        end else if (ready_q && win1) begin
          gnt1_d  = 1'b1;
          we_d    = we1;
          addr_d  = addr1;
          wdata_d = wdata1;
          prio_d  = 1'b0;
        end else begin
          we_d = 1'b0;
        end
      end
      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= {ADDR_W{1'b0}};
      ready_q   <= 1'b0;
      prio_q    <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= {ADDR_W{1'b0}};
      wdata_q   <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
      prio_q    <= prio_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign ready      = ready_q;
  assign gnt0       = gnt0_q;
  assign gnt1       = gnt1_q;
  assign rvalid0    = rvalid0_q;
  assign rvalid1    = rvalid1_q;
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign rdata      = bram_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: behavioural BRAMs, per-requester read-data scoreboards,
// and a second instance built without the zero-fill sequence.
module tb_bram_arbiter;
  localparam int AW = 5;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst, rst_b;
  always #5 clk = ~clk;

  // instance with clear
  logic          req0, we0, req1, we1, gnt0, gnt1, rvalid0, rvalid1, ready, bram_we;
  logic [AW-1:0] addr0, addr1, bram_addr;
  logic [DW-1:0] wdata0, wdata1, rdata, bram_wdata, bram_rdata;
  // instance without clear
  logic          b_req0, b_we0, b_req1, b_we1, b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_ready, b_bram_we;
  logic [AW-1:0] b_addr0, b_addr1, b_bram_addr;
  logic [DW-1:0] b_wdata0, b_wdata1, b_rdata, b_bram_wdata, b_bram_rdata;

  logic [DW-1:0] mem_a [32];
  logic [DW-1:0] mem_b [32];
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] q0 [$];
  logic [DW-1:0] q1 [$];
  logic          last_gnt;
  int            n_cmp = 0;
  int            n_bad = 0;

  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .ready(ready),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata)
  );

  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CLEAR_EN(1'b0)) u_dut_nc (
    .clk(clk), .rst(rst_b), .ready(b_ready),
    .req0(b_req0), .we0(b_we0), .addr0(b_addr0), .wdata0(b_wdata0), .gnt0(b_gnt0), .rvalid0(b_rvalid0),
    .req1(b_req1), .we1(b_we1), .addr1(b_addr1), .wdata1(b_wdata1), .gnt1(b_gnt1), .rvalid1(b_rvalid1),
    .rdata(b_rdata), .bram_we(b_bram_we), .bram_addr(b_bram_addr), .bram_wdata(b_bram_wdata),
    .bram_rdata(b_bram_rdata)
  );

  // single-port synchronous BRAM models, registered read
  always @(posedge clk) begin
    if (bram_we) mem_a[bram_addr] <= bram_wdata;
    bram_rdata <= mem_a[bram_addr];
    if (b_bram_we) mem_b[b_bram_addr] <= b_bram_wdata;
    b_bram_rdata <= mem_b[b_bram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    if (p == 0) begin
      req0 = v; we0 = we; addr0 = a; wdata0 = d;
    end else begin
      req1 = v; we1 = we; addr1 = a; wdata1 = d;
    end
  endtask

  // Single access from an idle arbiter: expects gnt one cycle after the req sample.
  task automatic access(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int   n;
    logic g;
    n = 0;
    set_req(p, 1'b1, we, a, d);
    do begin
      step();
      n++;
      g = (p == 0) ? gnt0 : gnt1;
    end while (!g && n < 20);
    check($sformatf("gnt_lat_p%0d", p), n, 1);
    check($sformatf("bram_side_p%0d", p), {bram_we, bram_addr, bram_wdata}, {we, a, d});
    set_req(p, 1'b0, we, a, d);
    last_gnt = p[0];
    if (we) begin
      ref_mem[a] = d;
      step();
    end else begin
      if (p == 0) q0.push_back(ref_mem[a]);
      else        q1.push_back(ref_mem[a]);
      step();
      check($sformatf("rv_lat_p%0d", p), (p == 0) ? rvalid0 : rvalid1, 1);
    end
  endtask

  // Called one cycle-slot after rst falls; walks the full zero-fill and the ready rise.
  task automatic check_clear();
    check("rst_vals", {ready, gnt0, gnt1, rvalid0, rvalid1, bram_we, bram_addr, bram_wdata}, 0);
    for (int k = 0; k < 32; k++) begin
      step();
      check("clr", {ready, gnt0, gnt1, bram_we, bram_addr, bram_wdata},
            {1'b0, 1'b0, 1'b0, 1'b1, 5'(k), 4'h0});
    end
    step();
    check("clr_done", {ready, bram_we, gnt0, gnt1}, 4'b1000);
    for (int k = 0; k < 32; k++) ref_mem[k] = 4'h0;
  endtask

  // Read-data scoreboard and mutual-exclusion monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (rvalid0) begin
        check("rv0_pending", 32'(q0.size() != 0), 1);
        if (q0.size() != 0) check("rdata0", rdata, q0.pop_front());
      end
      if (rvalid1) begin
        check("rv1_pending", 32'(q1.size() != 0), 1);
        if (q1.size() != 0) check("rdata1", rdata, q1.pop_front());
      end
      if (gnt0 | gnt1) check("gnt_excl", gnt0 & gnt1, 0);
      if (rvalid0 | rvalid1) check("rv_excl", rvalid0 & rvalid1, 0);
    end
  end

  initial begin
    logic w;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    b_req0 = 1'b0; b_we0 = 1'b0; b_addr0 = '0; b_wdata0 = '0;
    b_req1 = 1'b0; b_we1 = 1'b0; b_addr1 = '0; b_wdata1 = '0;
    rst = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", {ready, gnt0, gnt1, rvalid0, rvalid1, bram_we, bram_addr, bram_wdata}, 0);
    rst = 1'b0;

    // zero-fill, then idle
    check_clear();
    last_gnt = 1'b1;
    repeat (7) begin
      step();
      check("idle_we", bram_we, 0);
    end
    access(0, 1'b0, 5'd7, 4'h0);

    // write then read back from requester 0
    access(0, 1'b1, 5'd3, 4'hA);
    access(0, 1'b0, 5'd3, 4'h0);

    // preload and alternating reads with both requests held
    access(1, 1'b1, 5'd1, 4'h1);
    access(1, 1'b1, 5'd2, 4'h2);
    set_req(0, 1'b1, 1'b0, 5'd1, 4'h0);
    set_req(1, 1'b1, 1'b0, 5'd2, 4'h0);
    w = ~last_gnt;
    for (int k = 0; k < 8; k++) begin
      step();
      check("alt_gnt", {gnt1, gnt0}, w ? 2'b10 : 2'b01);
      if (w) q1.push_back(ref_mem[2]);
      else   q0.push_back(ref_mem[1]);
      w = ~w;
    end
    set_req(0, 1'b0, 1'b0, 5'd1, 4'h0);
    set_req(1, 1'b0, 1'b0, 5'd2, 4'h0);
    repeat (3) step();
    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    // reset in the gnt1 cycle of a read: the rvalid is dropped
    set_req(1, 1'b1, 1'b0, 5'd2, 4'h0);
    step();
    check("pre_rst_gnt1", {gnt1, bram_addr}, {1'b1, 5'd2});
    set_req(1, 1'b0, 1'b0, 5'd2, 4'h0);
    #1 rst = 1'b1;
    #1 check("async_rst", {ready, gnt0, gnt1, rvalid0, rvalid1, bram_we, bram_addr, bram_wdata}, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // requests raised during the re-run clear wait for ready
    set_req(0, 1'b1, 1'b0, 5'd3, 4'h0);
    set_req(1, 1'b1, 1'b0, 5'd5, 4'h0);
    check_clear();
    step();
    check("first_gnt", {gnt1, gnt0}, 2'b01);
    q0.push_back(ref_mem[3]);
    set_req(0, 1'b0, 1'b0, 5'd3, 4'h0);
    step();
    check("second_gnt", {gnt1, gnt0}, 2'b10);
    q1.push_back(ref_mem[5]);
    set_req(1, 1'b0, 1'b0, 5'd5, 4'h0);
    repeat (3) step();
    check("q0_after_clr", q0.size(), 0);
    check("q1_after_clr", q1.size(), 0);

    // instance without zero-fill
    rst_b = 1'b0;
    check("nc_rst", {b_ready, b_bram_we, b_gnt0, b_gnt1}, 0);
    step();
    check("nc_ready", {b_ready, b_bram_we}, 2'b10);
    b_req1 = 1'b1; b_we1 = 1'b1; b_addr1 = 5'd31; b_wdata1 = 4'h5;
    step();
    check("nc_wr", {b_gnt1, b_gnt0, b_bram_we, b_bram_addr, b_bram_wdata},
          {1'b1, 1'b0, 1'b1, 5'd31, 4'h5});
    b_req1 = 1'b0;
    step();
    check("nc_idle", {b_bram_we, b_gnt1}, 2'b00);
    b_req0 = 1'b1; b_we0 = 1'b0; b_addr0 = 5'd31;
    step();
    check("nc_rd_gnt", {b_gnt0, b_bram_we, b_bram_addr}, {1'b1, 1'b0, 5'd31});
    b_req0 = 1'b0;
    step();
    check("nc_rd_data", {b_rvalid0, b_rvalid1, b_rdata}, {1'b1, 1'b0, 4'h5});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
